// File: rtl/test_ctrl_pkg.sv
// Shared state encoding and mailbox constants for the test controller.
package test_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  localparam int unsigned PASS_VAL = 1;
  localparam logic        FAIL_LSB = 1'b1;

endpackage

// File: rtl/test_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/test_ctrl.sv
// Test harness controller: holds the core in reset, watches the tohost
// mailbox of every hart and reports pass, fail or timeout.
module test_ctrl
  import test_ctrl_pkg::*;
#(
  parameter int              N_HART         = 1,
  parameter int              XLEN           = 32,
  parameter longint unsigned TOHOST_ADDR    = 64'h0000_1000,
  parameter int              RST_CYCLES     = 4,
  parameter longint unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int              CNT_W          = 32,
  localparam int             HW             = $clog2(N_HART) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         restart,
  input  logic [N_HART-1:0]            st_valid,
  input  logic [N_HART-1:0][XLEN-1:0]  st_addr,
  input  logic [N_HART-1:0][XLEN-1:0]  st_data,
  input  logic [N_HART-1:0]            retire,
  output logic                         dut_rst_n,
  output logic                         done,
  output logic                         pass,
  output logic [HW-1:0]                fail_hart,
  output logic [XLEN-2:0]              fail_code,
  output logic [CNT_W-1:0]             cycle_cnt,
  output logic [N_HART-1:0][CNT_W-1:0] instret
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] HOLD_LAST = RW'(RST_CYCLES - 1);
  localparam longint unsigned TO_LAST = TIMEOUT_CYCLES - 1;

  state_e              state_q;
  logic [RW-1:0]       hold_q;
  logic [N_HART-1:0]   passed_q;
  logic [N_HART-1:0]   passed_d;
  logic [HW-1:0]       fail_hart_q;
  logic [XLEN-2:0]     fail_code_q;

  logic [N_HART-1:0]   mb_wr;
  logic [N_HART-1:0]   mb_pass;
  logic [N_HART-1:0]   mb_fail;
  logic [HW-1:0]       fail_idx;
  logic [XLEN-2:0]     fail_dat;
  logic                run;
  logic                to_hit;
  logic                clr;

  assign run = (state_q == ST_RUN);
  assign clr = rst | restart;
  assign to_hit = (64'(cycle_cnt) == TO_LAST);

  always_comb begin
    mb_wr    = '0;
    mb_pass  = '0;
    mb_fail  = '0;
    fail_idx = '0;
    fail_dat = '0;
    for (int h = 0; h < N_HART; h++) begin
      mb_wr[h]   = st_valid[h] && (st_addr[h] == XLEN'(TOHOST_ADDR));
      mb_pass[h] = mb_wr[h] && (st_data[h] == XLEN'(PASS_VAL));
      mb_fail[h] = mb_wr[h] && (st_data[h][0] == FAIL_LSB) && !mb_pass[h];
    end
    // Walk downwards so the lowest failing hart is the one kept.
    for (int h = N_HART - 1; h >= 0; h--) begin
      if (mb_fail[h]) begin
        fail_idx = HW'(h);
        fail_dat = st_data[h][XLEN-1:1];
      end
    end
  end

  assign passed_d = passed_q | mb_pass;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_RESET_HOLD;
      hold_q      <= '0;
      passed_q    <= '0;
      fail_hart_q <= '0;
      fail_code_q <= '0;
    end else begin
      unique case (state_q)
        ST_RESET_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= ST_RUN;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_RUN: begin
          passed_q <= passed_d;
          if (|mb_fail) begin
            state_q     <= ST_FAIL;
            fail_hart_q <= fail_idx;
            fail_code_q <= fail_dat;
          end else if (&passed_d) begin
            state_q <= ST_PASS;
          end else if (to_hit) begin
            state_q <= ST_TIMEOUT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk (clk),
    .clr (clr),
    .inc (run && !to_hit),
    .q   (cycle_cnt)
  );

  for (genvar h = 0; h < N_HART; h++) begin : g_ret
    sat_counter #(.W(CNT_W)) u_ret (
      .clk (clk),
      .clr (clr),
      .inc (run && retire[h]),
      .q   (instret[h])
    );
  end

  assign dut_rst_n = (state_q != ST_RESET_HOLD);
  assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL) ||
                     (state_q == ST_TIMEOUT);
  assign pass      = (state_q == ST_PASS);
  assign fail_hart = fail_hart_q;
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_test_ctrl.sv
// Scoreboard bench for test_ctrl: two instances, a 2-hart one with a
// short timeout and a 1-hart one with 4-bit counters.
module tb_test_ctrl;

  localparam logic [31:0] TH = 32'h0000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a = 1'b1;
  logic             restart_a = 1'b0;
  logic [1:0]       stv_a = '0;
  logic [1:0]       ret_a = '0;
  logic [1:0][31:0] sta_a = '0;
  logic [1:0][31:0] std_a = '0;
  logic             rstn_a, done_a, pass_a;
  logic [1:0]       fh_a;
  logic [30:0]      fc_a;
  logic [15:0]      cyc_a;
  logic [1:0][15:0] ins_a;

  logic             rst_b = 1'b1;
  logic             restart_b = 1'b0;
  logic [0:0]       stv_b = '0;
  logic [0:0]       ret_b = '0;
  logic [0:0][31:0] sta_b = '0;
  logic [0:0][31:0] std_b = '0;
  logic             rstn_b, done_b, pass_b;
  logic [0:0]       fh_b;
  logic [30:0]      fc_b;
  logic [3:0]       cyc_b;
  logic [0:0][3:0]  ins_b;

  test_ctrl #(
    .N_HART(2), .XLEN(32), .TOHOST_ADDR(64'h1000), .RST_CYCLES(4),
    .TIMEOUT_CYCLES(100), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst_a), .restart(restart_a),
    .st_valid(stv_a), .st_addr(sta_a), .st_data(std_a), .retire(ret_a),
    .dut_rst_n(rstn_a), .done(done_a), .pass(pass_a),
    .fail_hart(fh_a), .fail_code(fc_a), .cycle_cnt(cyc_a), .instret(ins_a)
  );

  test_ctrl #(
    .N_HART(1), .XLEN(32), .TOHOST_ADDR(64'h1000), .RST_CYCLES(4),
    .TIMEOUT_CYCLES(1_000_000), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst_b), .restart(restart_b),
    .st_valid(stv_b), .st_addr(sta_b), .st_data(std_b), .retire(ret_b),
    .dut_rst_n(rstn_b), .done(done_b), .pass(pass_b),
    .fail_hart(fh_b), .fail_code(fc_b), .cycle_cnt(cyc_b), .instret(ins_b)
  );

  typedef struct {
    logic pass;
    int   fhart;
    int   fcode;
    int   cyc;
    int   i0;
    int   i1;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(logic p, int fh, int fc, int cy, int i0, int i1);
    exp_t e;
    e.pass = p; e.fhart = fh; e.fcode = fc;
    e.cyc = cy; e.i0 = i0; e.i1 = i1;
    return e;
  endfunction

  // Monitors: a rising done is the DUT presenting its verdict.
  logic done_a_prev = 1'b0;
  logic done_b_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done_a === 1'b1 && done_a_prev !== 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_done actual=done expected=none");
      end else begin
        e = q_a.pop_front();
        chk("a_pass", 64'(pass_a), 64'(e.pass));
        chk("a_fail_hart", 64'(fh_a), 64'(e.fhart));
        chk("a_fail_code", 64'(fc_a), 64'(e.fcode));
        chk("a_cycle_cnt", 64'(cyc_a), 64'(e.cyc));
        chk("a_instret0", 64'(ins_a[0]), 64'(e.i0));
        chk("a_instret1", 64'(ins_a[1]), 64'(e.i1));
      end
    end
    done_a_prev = done_a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done_b === 1'b1 && done_b_prev !== 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_done actual=done expected=none");
      end else begin
        e = q_b.pop_front();
        chk("b_pass", 64'(pass_b), 64'(e.pass));
        chk("b_fail_hart", 64'(fh_b), 64'(e.fhart));
        chk("b_fail_code", 64'(fc_b), 64'(e.fcode));
        chk("b_cycle_cnt", 64'(cyc_b), 64'(e.cyc));
        chk("b_instret0", 64'(ins_b[0]), 64'(e.i0));
      end
    end
    done_b_prev = done_b;
  end

  task automatic idle_a();
    stv_a = '0; ret_a = '0; sta_a = '0; std_a = '0;
  endtask

  task automatic wr_a(int h, logic [31:0] ad, logic [31:0] d);
    stv_a[h] = 1'b1; sta_a[h] = ad; std_a[h] = d;
  endtask

  task automatic reset_vals_a(string tag);
    chk({tag, "_dut_rst_n"}, 64'(rstn_a), 64'd0);
    chk({tag, "_done"}, 64'(done_a), 64'd0);
    chk({tag, "_pass"}, 64'(pass_a), 64'd0);
    chk({tag, "_fail_hart"}, 64'(fh_a), 64'd0);
    chk({tag, "_fail_code"}, 64'(fc_a), 64'd0);
    chk({tag, "_cycle_cnt"}, 64'(cyc_a), 64'd0);
    chk({tag, "_instret"}, 64'(ins_a), 64'd0);
  endtask

  // Entered at hold cycle 0; leaves at RUN cycle 0.
  task automatic hold_seq_a();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("a_hold_rst_n_c%0d", i), 64'(rstn_a), 64'(i == 4));
    end
  endtask

  task automatic restart_seq_a(string tag);
    idle_a();
    restart_a = 1'b1;
    @(negedge clk);
    restart_a = 1'b0;
    reset_vals_a(tag);
    hold_seq_a();
  endtask

  task automatic wait_sb_a(int budget);
    for (int i = 0; i < budget && q_a.size() != 0; i++) @(negedge clk);
    checks++;
    if (q_a.size() != 0) begin
      failures++;
      $display("FAIL a_sb_timeout actual=pending%0d expected=0", q_a.size());
      q_a.delete();
    end
  endtask

  task automatic wait_sb_b(int budget);
    for (int i = 0; i < budget && q_b.size() != 0; i++) @(negedge clk);
    checks++;
    if (q_b.size() != 0) begin
      failures++;
      $display("FAIL b_sb_timeout actual=pending%0d expected=0", q_b.size());
      q_b.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset_vals_a("a_por");
    rst_a = 1'b0;
    hold_seq_a();

    // Hart0 passes, then hart1 reports 7.
    wr_a(0, TH, 32'd1);
    ret_a = 2'b01;
    @(negedge clk);
    idle_a();
    wr_a(1, TH, 32'd7);
    ret_a = 2'b01;
    q_a.push_back(mk(1'b0, 1, 3, 2, 2, 0));
    @(negedge clk);
    idle_a();
    wait_sb_a(10);

    // Terminal state ignores strobes and mailbox.
    ret_a = 2'b11;
    wr_a(0, TH, 32'd1);
    wr_a(1, TH, 32'd1);
    repeat (3) @(negedge clk);
    idle_a();
    chk("a_fail_frozen_cyc", 64'(cyc_a), 64'd2);
    chk("a_fail_frozen_ins0", 64'(ins_a[0]), 64'd2);
    chk("a_fail_frozen_pass", 64'(pass_a), 64'd0);
    chk("a_fail_frozen_hart", 64'(fh_a), 64'd1);

    // Same-cycle pass and fail: fail wins.
    restart_seq_a("a_rs1");
    wr_a(0, TH, 32'd1);
    wr_a(1, TH, 32'd5);
    q_a.push_back(mk(1'b0, 1, 2, 1, 0, 0));
    @(negedge clk);
    idle_a();
    wait_sb_a(10);

    // Timeout with no writes.
    restart_seq_a("a_rs2");
    q_a.push_back(mk(1'b0, 0, 0, 99, 0, 0));
    wait_sb_a(150);

    // Resolving write in the final budget cycle.
    restart_seq_a("a_rs3");
    q_a.push_back(mk(1'b1, 0, 0, 99, 0, 0));
    for (int k = 0; k < 100; k++) begin
      idle_a();
      if (k == 10) wr_a(0, TH, 32'd1);
      if (k == 99) wr_a(1, TH, 32'd1);
      @(negedge clk);
    end
    idle_a();
    wait_sb_a(10);

    // Restart out of PASS, then rst mid-run.
    restart_seq_a("a_rs4");
    ret_a = 2'b11;
    repeat (5) @(negedge clk);
    idle_a();
    chk("a_run5_cyc", 64'(cyc_a), 64'd5);
    chk("a_run5_ins1", 64'(ins_a[1]), 64'd5);
    rst_a = 1'b1;
    restart_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    restart_a = 1'b0;
    reset_vals_a("a_midrst");
    hold_seq_a();

    // Single hart with 4-bit counters.
    chk("b_por_rst_n", 64'(rstn_b), 64'd0);
    chk("b_por_done", 64'(done_b), 64'd0);
    chk("b_por_ins", 64'(ins_b), 64'd0);
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b_hold_rst_n_c%0d", i), 64'(rstn_b), 64'(i == 4));
    end
    ret_b = 1'b1;
    repeat (20) @(negedge clk);
    ret_b = 1'b0;
    chk("b_ins_sat", 64'(ins_b[0]), 64'd15);
    chk("b_cyc_sat", 64'(cyc_b), 64'd15);
    stv_b = 1'b1; sta_b[0] = TH; std_b[0] = 32'd2;
    @(negedge clk);
    sta_b[0] = TH + 32'd4; std_b[0] = 32'd1;
    @(negedge clk);
    stv_b = 1'b0; sta_b = '0; std_b = '0;
    @(negedge clk);
    chk("b_ignored_done", 64'(done_b), 64'd0);
    chk("b_ignored_rst_n", 64'(rstn_b), 64'd1);
    q_b.push_back(mk(1'b1, 0, 0, 15, 15, 0));
    stv_b = 1'b1; sta_b[0] = TH; std_b[0] = 32'd1;
    @(negedge clk);
    stv_b = 1'b0; sta_b = '0; std_b = '0;
    chk("b_pass_latency", 64'(pass_b), 64'd1);
    chk("b_done_latency", 64'(done_b), 64'd1);
    wait_sb_b(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_ctrl.md
TEST_CTRL -- requirements
Module: test_ctrl

Interface
REQ-001 Parameter N_HART, default 1: number of monitored cores (1..8).
REQ-002 Parameter XLEN, default 32: store address/data width.
REQ-003 Parameter TOHOST_ADDR, default 32'h0000_1000: pass/fail mailbox address.
REQ-004 Parameter RST_CYCLES, default 4: cycles the DUT reset is held (>=1).
REQ-005 Parameter TIMEOUT_CYCLES, default 1_000_000: run-cycle budget (>=1).
REQ-006 Parameter CNT_W, default 32: width of cycle and retire counters.
REQ-007 clk  in  1  single clock for all logic.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 restart  in  1  one-cycle pulse that re-runs the test from RESET_HOLD.
REQ-010 st_valid  in  N_HART  per-hart data-store valid.
REQ-011 st_addr  in  N_HART x XLEN  per-hart store address.
REQ-012 st_data  in  N_HART x XLEN  per-hart store data.
REQ-013 retire  in  N_HART  per-hart instruction-retired strobe.
REQ-014 dut_rst_n  out  1  active-low reset driven to the DUT.
REQ-015 done  out  1  test finished (PASS, FAIL or TIMEOUT).
REQ-016 pass  out  1  all harts reported pass.
REQ-017 fail_hart  out  clog2(N_HART)+1  lowest failing hart index.
REQ-018 fail_code  out  XLEN-1  failing mailbox data >> 1.
REQ-019 cycle_cnt  out  CNT_W  cycles spent in RUN.
REQ-020 instret  out  N_HART x CNT_W  per-hart retired-instruction count.

Function
REQ-021 The FSM SHALL have the states RESET_HOLD, RUN, PASS, FAIL and TIMEOUT.
REQ-022 RESET_HOLD: dut_rst_n=0 for exactly RST_CYCLES cycles, then -> RUN.
REQ-023 RUN: dut_rst_n=1; cycle_cnt +1 per cycle; instret[h] +1 per cycle with retire[h]=1.
REQ-024 Mailbox write = st_valid[h] && st_addr[h]==TOHOST_ADDR; writes to other addresses are ignored.
REQ-025 Mailbox data==1 SHALL set sticky passed[h]; data odd and !=1 is a failure; data even is ignored.
REQ-026 Any failure in RUN -> FAIL next cycle, latching fail_hart and fail_code from the lowest failing hart index that cycle.
REQ-027 RUN -> PASS when every passed[h] is set, including bits set that same cycle.
REQ-028 When pass and fail are reported in the same cycle, FAIL SHALL win.
REQ-029 RUN -> TIMEOUT when cycle_cnt reaches TIMEOUT_CYCLES-1 with no resolving mailbox write; a resolving write in that same cycle wins.
REQ-030 PASS, FAIL and TIMEOUT are terminal: done=1, counters frozen, dut_rst_n=1, mailbox ignored.
REQ-031 pass=1 only in PASS; fail_hart and fail_code SHALL be 0 unless in FAIL.
REQ-032 Counters saturate at all-ones, with no wrap.
REQ-033 restart in any state -> RESET_HOLD, clearing counters, passed[], fail fields and hold count.
REQ-034 Retire strobes and stores SHALL be ignored outside RUN.

Reset
REQ-035 rst=1 -> RESET_HOLD with hold counter 0, dut_rst_n=0, done=0, pass=0, fail_hart=0, fail_code=0, cycle_cnt=0, instret=0, passed=0.
REQ-036 rst asserted mid-run SHALL abort the run and behave identically to power-on reset; rst has priority over restart.

Structure
REQ-037 The package test_ctrl_pkg SHALL hold the state enum and the mailbox encoding constants (PASS_VAL=1, FAIL_LSB=1).
REQ-038 The sub-module sat_counter (parameter W; inputs clr, inc; output q) SHALL be instantiated for cycle_cnt and for each instret.

Verification
REQ-039 N_HART=1, RST_CYCLES=4: dut_rst_n=0 for cycles 0-3 after rst release, 1 from cycle 4; store 1 to TOHOST -> pass=1 and done=1 the next cycle.
REQ-040 N_HART=2: hart0 writes 1, then hart1 writes 7 -> FAIL, fail_hart=1, fail_code=3, pass=0.
REQ-041 Same cycle: hart0 writes 1 and hart1 writes 5 -> FAIL, fail_hart=1, fail_code=2.
REQ-042 TIMEOUT_CYCLES=100 with no writes -> done=1 after 100 RUN cycles, pass=0, cycle_cnt=99; a write of 1 in cycle 99 -> PASS instead.
REQ-043 CNT_W=4 with 20 retire pulses -> instret saturates at 15; a store of 2 to TOHOST or of 1 to TOHOST+4 does not change state.
REQ-044 restart pulse in PASS, and rst in RUN -> all outputs return to reset values and the RESET_HOLD sequence repeats.
